pc_stack_sequencer: RTL and testbench

- Initiator side of the program-counter stack interface (execute / instruction / carry_in / output_enable / data_in in; address_out / carry_out / stack_full / stack_empty back).
- Turns MC14500B ICU control flags (JMP, JSR, RTN) and the program-memory target field into correctly sequenced stack commands.
- Captures the returned address as the current program counter and flags stack overflow and underflow.
- Sits between the ICU/program-memory fetch path and the PC stack.

---
 rtl/pc_stack_sequencer_pkg.sv | 33 +++
 rtl/pc_stack_sequencer_cmd_issuer.sv | 56 +++++
 rtl/pc_stack_sequencer.sv | 119 +++++++++++
 tb/tb_pc_stack_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_sequencer_pkg.sv
// Shared types for the PC stack sequencer: stack opcodes, sequencer states
// and the ICU flag decode.
package pc_stack_pkg;

    localparam int SETTLE_MAX = 3;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_INC  = 2'b11
    } stk_op_t;

    typedef enum logic [2:0] {
        READY   = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        POSTINC = 3'd4,
        ERROR   = 3'd5
    } seq_state_t;

    // RTN outranks JSR outranks JMP; no flag means a plain increment.
    function automatic stk_op_t decode_op(input logic rtn, input logic jsr, input logic jmp);
        stk_op_t op;
        if (rtn)      op = OP_POP;
        else if (jsr) op = OP_PUSH;
        else if (jmp) op = OP_LOAD;
        else          op = OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_sequencer_cmd_issuer.sv
// Execute/settle/capture timing for one stack command. A start seen while
// capturing chains straight into the next command with no idle cycle.
module pc_stack_cmd_issuer
    import pc_stack_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic execute,
    output logic output_enable,
    output logic capture
);

    if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_settle_range
        $error("pc_stack_cmd_issuer: SETTLE must be 0..3");
    end

    seq_state_t phase;
    logic [1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= READY;
            cnt   <= 2'd0;
        end else begin
            case (phase)
                READY: begin
                    if (start) phase <= ISSUE;
                end
                ISSUE: begin
                    if (SETTLE == 0) begin
                        phase <= CAPTURE;
                    end else begin
                        phase <= WAIT;
                        cnt   <= 2'(SETTLE - 1);
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) phase <= CAPTURE;
                    else             cnt   <= cnt - 2'd1;
                end
                CAPTURE: begin
                    phase <= start ? ISSUE : READY;
                end
                default: phase <= READY;
            endcase
        end
    end

    assign execute       = (phase == ISSUE);
    assign output_enable = (phase == CAPTURE);
    assign capture       = (phase == CAPTURE);

endmodule

// File: rtl/pc_stack_sequencer.sv
// Turns ICU JMP/JSR/RTN flags into sequenced PC stack commands, captures the
// returned address as the program counter and flags stack over/underflow.
module pc_stack_sequencer
    import pc_stack_pkg::*;
#(
    parameter int WORD   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            step,
    input  logic            icu_jmp,
    input  logic            icu_jsr,
    input  logic            icu_rtn,
    input  logic [WORD-1:0] target,
    output logic            stk_execute,
    output logic [1:0]      stk_instruction,
    output logic            stk_carry_in,
    output logic            stk_output_enable,
    output logic [WORD-1:0] stk_data_in,
    input  logic [WORD-1:0] stk_address,
    input  logic            stk_carry_out,
    input  logic            stk_full,
    input  logic            stk_empty,
    output logic [WORD-1:0] pc,
    output logic            pc_valid,
    output logic            wrap,
    output logic            ovf_err,
    output logic            unf_err
);

    seq_state_t      state;
    stk_op_t         op;
    stk_op_t         req_op;
    logic            carry_q;
    logic [WORD-1:0] data_q;
    logic            req_unf;
    logic            req_ovf;
    logic            accept;
    logic            chain;
    logic            start;
    logic            capture;

    assign req_op  = decode_op(icu_rtn, icu_jsr, icu_jmp);
    assign accept  = (state == READY) && step;
    assign req_unf = (req_op == OP_POP)  && stk_empty;
    assign req_ovf = (req_op == OP_PUSH) && stk_full;
    // A completed pop is followed immediately by the resume increment.
    assign chain   = capture && (state == ISSUE) && (op == OP_POP);
    assign start   = (accept && !req_unf && !req_ovf) || chain;

    pc_stack_cmd_issuer #(
        .SETTLE (SETTLE)
    ) u_issuer (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .execute       (stk_execute),
        .output_enable (stk_output_enable),
        .capture       (capture)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= READY;
            op      <= OP_INC;
            carry_q <= 1'b1;
            data_q  <= '0;
            pc      <= '0;
            wrap    <= 1'b0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                READY: begin
                    if (step) begin
                        if (req_unf) begin
                            unf_err <= 1'b1;
                            state   <= ERROR;
                        end else if (req_ovf) begin
                            ovf_err <= 1'b1;
                            state   <= ERROR;
                        end else begin
                            op      <= req_op;
                            carry_q <= (req_op != OP_INC);
                            data_q  <= (req_op == OP_LOAD || req_op == OP_PUSH) ? target : '0;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE, POSTINC: begin
                    if (capture) begin
                        pc <= stk_address;
                        if (op == OP_INC && !stk_carry_out) wrap <= 1'b1;
                        if (chain) begin
                            op      <= OP_INC;
                            carry_q <= 1'b0;
                            state   <= POSTINC;
                        end else begin
                            // Park the command bus on an inhibited increment.
                            op      <= OP_INC;
                            carry_q <= 1'b1;
                            data_q  <= '0;
                            state   <= READY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stk_instruction = op;
    assign stk_carry_in    = carry_q;
    assign stk_data_in     = data_q;
    assign pc_valid        = (state == READY);

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench: two sequencers (SETTLE 0 and 2) each driving a small
// behavioural PC stack.
module tb_pc_stack_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int lat;
    int execs;
    logic [3:0] ops;

    // ---------------- DUT 0: SETTLE = 0 ----------------
    logic       rst_n, step, jmp, jsr, rtn;
    logic [3:0] target;
    logic       execute, carry_in, oe, carry_out, full, empty;
    logic [1:0] instr;
    logic [3:0] data_in, address, pc;
    logic       pc_valid, wrap, ovf_err, unf_err;
    logic       force_full;

    pc_stack_sequencer #(.WORD(4), .SETTLE(0)) u_dut (
        .clk (clk), .reset (rst_n), .step (step),
        .icu_jmp (jmp), .icu_jsr (jsr), .icu_rtn (rtn), .target (target),
        .stk_execute (execute), .stk_instruction (instr), .stk_carry_in (carry_in),
        .stk_output_enable (oe), .stk_data_in (data_in), .stk_address (address),
        .stk_carry_out (carry_out), .stk_full (full), .stk_empty (empty),
        .pc (pc), .pc_valid (pc_valid), .wrap (wrap),
        .ovf_err (ovf_err), .unf_err (unf_err)
    );

    // Behavioural 4-deep stack; the top entry is the address presented.
    logic [3:0] tos;
    logic [3:0] mem [4];
    logic [2:0] depth;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos <= 4'h0; depth <= 3'd0; carry_out <= 1'b1;
        end else if (execute) begin
            case (instr)
                2'b00: tos <= data_in;
                2'b01: begin mem[depth[1:0]] <= tos; depth <= depth + 3'd1; tos <= data_in; end
                2'b10: begin tos <= mem[2'(depth - 3'd1)]; depth <= depth - 3'd1; end
                2'b11: if (!carry_in) begin tos <= tos + 4'h1; carry_out <= (tos != 4'hF); end
                default: ;
            endcase
        end
    end
    assign address = tos;
    assign full    = (depth == 3'd4) || force_full;
    assign empty   = (depth == 3'd0);

    // ---------------- DUT 2: SETTLE = 2 ----------------
    logic       rst2_n, step2, jmp2;
    logic       zero2 = 1'b0, one2 = 1'b1;
    logic [3:0] target2;
    logic       execute2, carry_in2, oe2;
    logic [1:0] instr2;
    logic [3:0] data_in2, pc2;
    logic       pc_valid2, wrap2, ovf2, unf2;
    logic [3:0] tos2;

    pc_stack_sequencer #(.WORD(4), .SETTLE(2)) u_dut2 (
        .clk (clk), .reset (rst2_n), .step (step2),
        .icu_jmp (jmp2), .icu_jsr (zero2), .icu_rtn (zero2), .target (target2),
        .stk_execute (execute2), .stk_instruction (instr2), .stk_carry_in (carry_in2),
        .stk_output_enable (oe2), .stk_data_in (data_in2), .stk_address (tos2),
        .stk_carry_out (one2), .stk_full (zero2), .stk_empty (zero2),
        .pc (pc2), .pc_valid (pc_valid2), .wrap (wrap2),
        .ovf_err (ovf2), .unf_err (unf2)
    );

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) tos2 <= 4'h0;
        else if (execute2 && instr2 == 2'b00) tos2 <= data_in2;
        else if (execute2 && instr2 == 2'b11 && !carry_in2) tos2 <= tos2 + 4'h1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse step with the given flags, then follow the op until READY (bounded).
    task automatic do_step(input logic r, input logic j, input logic m, input logic [3:0] t);
        @(negedge clk);
        step = 1'b1; rtn = r; jsr = j; jmp = m; target = t;
        @(negedge clk);
        step = 1'b0; rtn = 1'b0; jsr = 1'b0; jmp = 1'b0;
        lat   = 1;
        execs = execute ? 1 : 0;
        ops   = execute ? (4'b0001 << instr) : 4'b0000;
        while (!pc_valid && lat < 12) begin
            @(negedge clk);
            lat++;
            if (execute) begin
                execs++;
                ops = ops | (4'b0001 << instr);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; force_full = 1'b0;
        step = 1'b0; jmp = 1'b0; jsr = 1'b0; rtn = 1'b0; target = 4'h0;
        step2 = 1'b0; jmp2 = 1'b0; target2 = 4'h0;
        @(negedge clk); @(negedge clk);

        check("rst_pc", pc, 4'h0);
        check("rst_pc_valid", pc_valid, 1'b1);
        check("rst_execute", execute, 1'b0);
        check("rst_instr", instr, 2'b11);
        check("rst_carry_in", carry_in, 1'b1);
        check("rst_oe", oe, 1'b0);
        check("rst_data_in", data_in, 4'h0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_unf", unf_err, 1'b0);
        rst_n = 1'b1;

        // Plain increments from 0
        for (int i = 1; i <= 3; i++) begin
            do_step(1'b0, 1'b0, 1'b0, 4'h0);
            check($sformatf("inc%0d_pc", i), pc, 32'(i));
            check($sformatf("inc%0d_lat", i), lat, 3);
            check($sformatf("inc%0d_execs", i), execs, 1);
            check($sformatf("inc%0d_ops", i), ops, 4'b1000);
        end

        // Call and return
        do_step(1'b0, 1'b1, 1'b0, 4'hA);
        check("jsr_pc", pc, 4'hA);
        check("jsr_ops", ops, 4'b0010);
        check("jsr_lat", lat, 3);
        do_step(1'b1, 1'b0, 1'b0, 4'h0);
        check("rtn_pc", pc, 4'h4);
        check("rtn_lat", lat, 5);
        check("rtn_execs", execs, 2);
        check("rtn_ops", ops, 4'b1100);

        // All flags at once on a non-empty stack: pop path only
        do_step(1'b0, 1'b1, 1'b0, 4'h7);
        check("jsr7_pc", pc, 4'h7);
        do_step(1'b1, 1'b1, 1'b1, 4'h9);
        check("all_pc", pc, 4'h5);
        check("all_ops", ops, 4'b1100);
        check("all_lat", lat, 5);

        // Wrap at the top of the address space
        do_step(1'b0, 1'b0, 1'b1, 4'hE);
        check("jmp_pc", pc, 4'hE);
        check("jmp_ops", ops, 4'b0001);
        do_step(1'b0, 1'b0, 1'b0, 4'h0);
        check("incF_pc", pc, 4'hF);
        check("incF_wrap", wrap, 1'b0);
        do_step(1'b0, 1'b0, 1'b0, 4'h0);
        check("inc0_pc", pc, 4'h0);
        check("inc0_wrap", wrap, 1'b1);
        @(negedge clk);
        check("inc0_wrap_end", wrap, 1'b0);

        // Underflow on an empty stack
        pulse_reset();
        do_step(1'b1, 1'b0, 1'b0, 4'h0);
        check("unf_err", unf_err, 1'b1);
        check("unf_ovf", ovf_err, 1'b0);
        check("unf_pc_valid", pc_valid, 1'b0);
        check("unf_execs", execs, 0);
        check("unf_carry_in", carry_in, 1'b1);

        // Overflow, sticky ERROR until reset
        pulse_reset();
        do_step(1'b0, 1'b0, 1'b0, 4'h0);
        check("pre_ovf_pc", pc, 4'h1);
        force_full = 1'b1;
        do_step(1'b0, 1'b1, 1'b0, 4'h5);
        check("ovf_err", ovf_err, 1'b1);
        check("ovf_execs", execs, 0);
        check("ovf_pc_valid", pc_valid, 1'b0);
        check("ovf_pc", pc, 4'h1);
        do_step(1'b0, 1'b0, 1'b0, 4'h0);
        check("err_ignore_execs", execs, 0);
        check("err_ignore_pc", pc, 4'h1);
        force_full = 1'b0;
        pulse_reset();
        check("post_rst_pc", pc, 4'h0);
        check("post_rst_ovf", ovf_err, 1'b0);
        check("post_rst_pc_valid", pc_valid, 1'b1);

        // SETTLE = 2: reset during WAIT of a JMP
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        step2 = 1'b1; jmp2 = 1'b1; target2 = 4'h9;
        @(negedge clk);
        step2 = 1'b0; jmp2 = 1'b0;
        check("s2_issue_exec", execute2, 1'b1);
        @(negedge clk);
        check("s2_wait_exec", execute2, 1'b0);
        check("s2_wait_oe", oe2, 1'b0);
        check("s2_wait_data", data_in2, 4'h9);
        check("s2_wait_instr", instr2, 2'b00);
        rst2_n = 1'b0;
        #1;
        check("s2_abort_pc", pc2, 4'h0);
        check("s2_abort_pc_valid", pc_valid2, 1'b1);
        check("s2_abort_instr", instr2, 2'b11);
        check("s2_abort_carry", carry_in2, 1'b1);
        check("s2_abort_data", data_in2, 4'h0);
        check("s2_abort_exec", execute2, 1'b0);
        @(negedge clk);
        rst2_n = 1'b1;

        // SETTLE = 2: full JMP latency
        @(negedge clk);
        step2 = 1'b1; jmp2 = 1'b1; target2 = 4'h6;
        @(negedge clk);
        step2 = 1'b0; jmp2 = 1'b0;
        lat = 1;
        execs = execute2 ? 1 : 0;
        while (!pc_valid2 && lat < 12) begin
            @(negedge clk);
            lat++;
            if (execute2) execs++;
        end
        check("s2_jmp_lat", lat, 5);
        check("s2_jmp_execs", execs, 1);
        check("s2_jmp_pc", pc2, 4'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
